lcd_write_arbiter: RTL and testbench

- Shares one LCD byte-write controller (start/done handshake, 8-bit data + RS) between two requesters, e.g. the display-memory scanner (port 0) and a status/debug writer (port 1).
- Sequences each write as: arbitrate, start pulse, wait for done, post-write settle delay, acknowledge.
- Round-robin fairness, plus an optional lock so a requester can keep the bus for multi-byte bursts (cursor set + characters).
- Done-timeout with an error flag.

---
 rtl/lcd_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//
// Shares one LCD byte-write controller (start/done handshake, 8-bit data
// plus RS) between two requesters. Each write is sequenced as: arbitrate,
// one-cycle start pulse, wait for done, post-write settle delay, then a
// one-cycle acknowledge to the requester.
//
// Arbitration is round-robin. A requester can keep the bus for multi-byte
// bursts by setting its lock bit. The lock is released when the owner
// completes a byte with lock=0, or when the owner leaves valid low for
// LOCK_IDLE consecutive idle cycles. A missing done is aborted after
// TIMEOUT cycles with a one-cycle err pulse, and the byte is still acked.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid0/1             requester has a byte pending
//   req_data0/1 [8:0]        [8]=RS, [7:0]=byte, held stable until ack
//   req_lock0/1              keep the grant after this byte
//   req_ack0/1               one-cycle completion pulse
//   lcd_data [7:0], lcd_rs   byte and RS towards the controller
//   lcd_start                one-cycle start pulse towards the controller
//   lcd_done                 controller reports write complete
//   grant [1:0]              one-hot current owner, 00 when idle
//   busy                     high in every state except IDLE
//   err                      one-cycle pulse on a timeout abort
module lcd_write_arbiter #(
  parameter int DLY_W      = 18,
  parameter int DLY_CYCLES = 262142,
  parameter int TIMEOUT    = 262143,
  parameter int LOCK_IDLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid0,
  input  logic [8:0] req_data0,
  input  logic       req_lock0,
  output logic       req_ack0,
  input  logic       req_valid1,
  input  logic [8:0] req_data1,
  input  logic       req_lock1,
  output logic       req_ack1,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_start,
  input  logic       lcd_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DLY   = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  localparam int LI_W = (LOCK_IDLE > 1) ? $clog2(LOCK_IDLE) : 1;

  // Terminal counts. With DLY_CYCLES=0 the DLY state is never entered,
  // so its terminal value is irrelevant and only needs to be legal.
  localparam logic [DLY_W-1:0] TO_LAST  = DLY_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = (DLY_CYCLES > 0) ? DLY_W'(DLY_CYCLES - 1) : '0;
  localparam logic [LI_W-1:0]  LI_LAST  = LI_W'(LOCK_IDLE - 1);

  logic [2:0]       state;
  logic [DLY_W-1:0] cnt;
  logic [LI_W-1:0]  lidle;
  logic             last;      // port served most recently
  logic             lock;
  logic             lock_req;  // lock bit of the byte in flight
  logic             lock_own;

  logic             win_valid;
  logic             win_sel;
  logic [8:0]       sel_data;
  logic             sel_lock;

  // Winner selection in IDLE: a held lock restricts eligibility to the
  // owner; otherwise a tie goes to the port that was not served last.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = 1'b0;
    if (lock) begin
      win_valid = lock_own ? req_valid1 : req_valid0;
      win_sel   = lock_own;
    end else if (req_valid0 && req_valid1) begin
      win_valid = 1'b1;
      win_sel   = ~last;
    end else if (req_valid0) begin
      win_valid = 1'b1;
      win_sel   = 1'b0;
    end else if (req_valid1) begin
      win_valid = 1'b1;
      win_sel   = 1'b1;
    end
  end

  assign sel_data = win_sel ? req_data1 : req_data0;
  assign sel_lock = win_sel ? req_lock1 : req_lock0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lidle    <= '0;
      last     <= 1'b1;
      lock     <= 1'b0;
      lock_req <= 1'b0;
      lock_own <= 1'b0;
      grant    <= 2'b00;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            lcd_data <= sel_data[7:0];
            lcd_rs   <= sel_data[8];
            lock_req <= sel_lock;
            grant    <= win_sel ? 2'b10 : 2'b01;
            lidle    <= '0;
            state    <= S_START;
          end else if (lock) begin
            // Owner absent while locked: give the bus back after
            // LOCK_IDLE consecutive idle cycles.
            if (lidle == LI_LAST) begin
              lock  <= 1'b0;
              lidle <= '0;
            end else begin
              lidle <= lidle + 1'b1;
            end
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done is tested first so a done coinciding with the last
          // timeout cycle completes normally without err.
          if (lcd_done) begin
            cnt   <= '0;
            state <= (DLY_CYCLES == 0) ? S_ACK : S_DLY;
          end else if (cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= S_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DLY: begin
          if (cnt == DLY_LAST) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          last     <= grant[1];
          lock     <= lock_req;
          lock_own <= grant[1];
          lidle    <= '0;
          grant    <= 2'b00;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from registered state only.
  assign lcd_start = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign req_ack0  = (state == S_ACK) && grant[0];
  assign req_ack1  = (state == S_ACK) && grant[1];

endmodule

// File: tb/tb_lcd_write_arbiter.sv
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

  localparam int DLY_W = 8;
  localparam int DLY   = 4;
  localparam int TO    = 8;
  localparam int LI    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid0 = 1'b0, req_lock0 = 1'b0;
  logic       req_valid1 = 1'b0, req_lock1 = 1'b0;
  logic [8:0] req_data0 = 9'h000, req_data1 = 9'h000;
  logic       lcd_done = 1'b0;
  logic       req_ack0, req_ack1, lcd_start, lcd_rs, busy, err;
  logic [7:0] lcd_data;
  logic [1:0] grant;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .DLY_W(DLY_W), .DLY_CYCLES(DLY), .TIMEOUT(TO), .LOCK_IDLE(LI)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_data0(req_data0), .req_lock0(req_lock0), .req_ack0(req_ack0),
    .req_valid1(req_valid1), .req_data1(req_data1), .req_lock1(req_lock1), .req_ack1(req_ack1),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_start(lcd_start), .lcd_done(lcd_done),
    .grant(grant), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model (transaction timestamps) ----------------
  int         cyc = 0;
  bit         m_act = 1'b0;
  int         m_owner = 0;
  int         m_start = -1;
  int         m_ack = -1;
  bit         m_to = 1'b0;
  int         m_last = 1;
  bit         m_lock = 1'b0;
  bit         m_lock_req = 1'b0;
  int         m_lock_own = 0;
  int         m_lidle = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_rs = 1'b0;
  int         m_prev, m_w;
  bit         m_ownv;

  initial forever begin
    @(posedge clk);
    m_prev = cyc;
    cyc = cyc + 1;
    if (rst) begin
      m_act = 0; m_last = 1; m_lock = 0; m_lidle = 0;
      m_data = 8'h00; m_rs = 1'b0; m_to = 0; m_ack = -1;
    end else if (!m_act) begin
      m_w = -1;
      if (m_lock) begin
        m_ownv = (m_lock_own == 1) ? req_valid1 : req_valid0;
        if (m_ownv) begin
          m_w = m_lock_own;
          m_lidle = 0;
        end else begin
          m_lidle = m_lidle + 1;
          if (m_lidle == LI) begin m_lock = 0; m_lidle = 0; end
        end
      end else if (req_valid0 && req_valid1) begin
        m_w = (m_last == 1) ? 0 : 1;
      end else if (req_valid0) begin
        m_w = 0;
      end else if (req_valid1) begin
        m_w = 1;
      end
      if (m_w >= 0) begin
        m_act = 1; m_owner = m_w; m_start = cyc; m_ack = -1; m_to = 0;
        {m_rs, m_data} = (m_w == 1) ? req_data1 : req_data0;
        m_lock_req = (m_w == 1) ? req_lock1 : req_lock0;
      end
    end else begin
      if (m_prev == m_ack) begin
        m_act = 0; m_last = m_owner; m_lock = m_lock_req;
        m_lock_own = m_owner; m_lidle = 0;
      end else if (m_ack < 0 && m_prev > m_start) begin
        if (lcd_done) m_ack = m_prev + DLY + 1;
        else if (m_prev - m_start == TO) begin m_ack = m_prev + 1; m_to = 1; end
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  typedef struct {
    int         cyc;
    int         port;
    logic [8:0] d;
    logic [1:0] g;
    bit         e;
  } ev_t;

  ev_t  ack_log[$];
  int   start_cyc[$];
  int   start_port[$];
  int   err_cyc[$];
  bit   ack_seen0 = 1'b0, ack_seen1 = 1'b0;
  ev_t  ev;
  logic [15:0] act_v, exp_v;
  logic [1:0]  e_grant;

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      e_grant = m_act ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_v = {e_grant, m_act, (m_act && cyc == m_start),
               (m_act && cyc == m_ack && m_owner == 1),
               (m_act && cyc == m_ack && m_owner == 0),
               (m_act && cyc == m_ack && m_to), m_rs, m_data};
      act_v = {grant, busy, lcd_start, req_ack1, req_ack0, err, lcd_rs, lcd_data};
      n_cmp = n_cmp + 1;
      if (act_v !== exp_v) begin
        n_bad = n_bad + 1;
        $display("FAIL cycle_outputs cyc=%0d {grant,busy,start,ack1,ack0,err,rs,data} got=%h want=%h",
                 cyc, act_v, exp_v);
      end
      ack_seen0 = req_ack0;
      ack_seen1 = req_ack1;
      if (lcd_start === 1'b1) begin
        start_cyc.push_back(cyc);
        start_port.push_back(int'(grant[1]));
      end
      if (req_ack0 === 1'b1 || req_ack1 === 1'b1) begin
        ev.cyc = cyc; ev.port = int'(req_ack1); ev.d = {lcd_rs, lcd_data};
        ev.g = grant; ev.e = err;
        ack_log.push_back(ev);
      end
      if (err === 1'b1) err_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus: requesters and controller ----------------
  typedef struct {
    int         gap;
    bit         lock;
    logic [8:0] data;
  } item_t;

  item_t q0[$], q1[$];
  item_t it;
  bit    pend0 = 1'b0, pend1 = 1'b0;
  int    wt0 = 0, wt1 = 0;
  int    done_dly = 3;
  bit    done_rand = 1'b0;
  int    done_cnt = -1;
  int    spur_pct = 0;
  int    noise_pct = 0;

  function automatic item_t mk(int gap, bit lock, logic [8:0] data);
    item_t r;
    r.gap = gap; r.lock = lock; r.data = data;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    if (ack_seen0) pend0 = 1'b0;
    if (!pend0 && q0.size() > 0) begin
      if (wt0 < q0[0].gap) wt0 = wt0 + 1;
      else begin
        it = q0.pop_front();
        req_data0 = it.data; req_lock0 = it.lock; pend0 = 1'b1; wt0 = 0;
      end
    end
    req_valid0 = pend0;
    if (ack_seen1) pend1 = 1'b0;
    if (!pend1 && q1.size() > 0) begin
      if (wt1 < q1[0].gap) wt1 = wt1 + 1;
      else begin
        it = q1.pop_front();
        req_data1 = it.data; req_lock1 = it.lock; pend1 = 1'b1; wt1 = 0;
      end
    end
    req_valid1 = pend1;
    lcd_done = 1'b0;
    if (lcd_start === 1'b1) begin
      done_cnt = done_rand ? int'($urandom_range(1, 9)) : done_dly;
      if (int'($urandom_range(0, 99)) < spur_pct) lcd_done = 1'b1;
    end else if (done_cnt > 0) begin
      done_cnt = done_cnt - 1;
      if (done_cnt == 0) begin lcd_done = 1'b1; done_cnt = -1; end
    end
    if (int'($urandom_range(0, 99)) < noise_pct) lcd_done = 1'b1;
  endtask

  task automatic chk(string name, int got, int want);
    n_cmp = n_cmp + 1;
    if (got != want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run_until_acks(string name, int n, int budget);
    int k;
    k = 0;
    while (ack_log.size() < n && k < budget) begin step(); k++; end
    chk({name, "_ack_count"}, ack_log.size(), n);
  endtask

  task automatic clear_logs();
    ack_log.delete(); start_cyc.delete(); start_port.delete(); err_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic int outs_now();
    return int'({grant, busy, lcd_start, req_ack1, req_ack0, err, lcd_rs, lcd_data});
  endfunction

  initial begin
    int k;
    do_reset();
    chk("reset_state", outs_now(), 0);

    // 1: single write, done 3 cycles after start, 4 settle cycles
    clear_logs();
    done_dly = 3;
    q0.push_back(mk(0, 1'b0, 9'h038));
    run_until_acks("s1", 1, 100);
    if (ack_log.size() >= 1 && start_cyc.size() >= 1) begin
      chk("s1_port", ack_log[0].port, 0);
      chk("s1_data", int'(ack_log[0].d), 'h038);
      chk("s1_grant", int'(ack_log[0].g), 1);
      chk("s1_start_to_ack", ack_log[0].cyc - start_cyc[0], 8);
    end
    chk("s1_starts", start_cyc.size(), 1);
    step();
    chk("s1_busy_after", int'(busy), 0);

    // 2: both valid from reset, round-robin 0,1,0,1
    do_reset();
    clear_logs();
    q0.push_back(mk(0, 1'b0, 9'h041)); q0.push_back(mk(0, 1'b0, 9'h041));
    q1.push_back(mk(0, 1'b0, 9'h142)); q1.push_back(mk(0, 1'b0, 9'h142));
    run_until_acks("s2", 4, 200);
    if (ack_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("s2_order%0d", i), ack_log[i].port, i % 2);
      chk("s2_rs_data", int'(ack_log[1].d), 'h142);
    end

    // 3: locked burst from port 0 keeps port 1 waiting
    clear_logs();
    q0.push_back(mk(0, 1'b1, 9'h0A1)); q0.push_back(mk(0, 1'b1, 9'h0A2));
    q0.push_back(mk(0, 1'b0, 9'h0A3));
    q1.push_back(mk(0, 1'b0, 9'h1B4));
    run_until_acks("s3", 4, 300);
    if (ack_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("s3_order%0d", i), ack_log[i].port, (i == 3) ? 1 : 0);
      chk("s3_third_data", int'(ack_log[2].d), 'h0A3);
    end

    // 4: lock owner goes quiet; port 1 waits out LOCK_IDLE idle cycles
    clear_logs();
    q0.push_back(mk(0, 1'b1, 9'h0C5));
    q1.push_back(mk(0, 1'b0, 9'h1D6));
    run_until_acks("s4", 2, 300);
    if (ack_log.size() >= 2 && start_cyc.size() >= 2) begin
      chk("s4_first_port", ack_log[0].port, 0);
      chk("s4_second_port", ack_log[1].port, 1);
      chk("s4_ack_to_start1", start_cyc[1] - ack_log[0].cyc, 18);
    end

    // 5a: done never arrives -> timeout abort
    clear_logs();
    done_dly = -1;
    q0.push_back(mk(0, 1'b0, 9'h0E7));
    run_until_acks("s5a", 1, 100);
    if (ack_log.size() >= 1 && start_cyc.size() >= 1) begin
      chk("s5a_start_to_ack", ack_log[0].cyc - start_cyc[0], 9);
      chk("s5a_err_with_ack", int'(ack_log[0].e), 1);
    end
    chk("s5a_err_pulses", err_cyc.size(), 1);
    step();
    chk("s5a_idle_after", int'(busy), 0);

    // 5b: done on the final timeout cycle -> normal completion
    clear_logs();
    done_dly = 8;
    q0.push_back(mk(0, 1'b0, 9'h0E8));
    run_until_acks("s5b", 1, 100);
    if (ack_log.size() >= 1 && start_cyc.size() >= 1)
      chk("s5b_start_to_ack", ack_log[0].cyc - start_cyc[0], 13);
    chk("s5b_err_pulses", err_cyc.size(), 0);

    // 6: reset during the settle delay of a port 1 write
    clear_logs();
    done_dly = 2;
    q1.push_back(mk(0, 1'b0, 9'h1F9));
    k = 0;
    while (start_cyc.size() == 0 && k < 50) begin step(); k++; end
    chk("s6_started", start_cyc.size(), 1);
    repeat (4) step();
    chk("s6_in_dly_busy", int'(busy), 1);
    rst = 1'b1;
    q0.push_back(mk(0, 1'b0, 9'h010));
    step();
    chk("s6_reset_outputs", outs_now(), 0);
    rst = 1'b0;
    run_until_acks("s6", 2, 200);
    if (ack_log.size() >= 2) begin
      chk("s6_first_after_reset", ack_log[0].port, 0);
      chk("s6_second_after_reset", ack_log[1].port, 1);
    end

    // 7: randomized traffic, controller timing, spurious done and resets
    clear_logs();
    done_rand = 1'b1; spur_pct = 20; noise_pct = 3;
    for (int i = 0; i < 80; i++) begin
      q0.push_back(mk(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      9'($urandom_range(0, 511))));
      q1.push_back(mk(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      9'($urandom_range(0, 511))));
    end
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend0 || pend1) && k < 20000) begin
      rst = ($urandom_range(0, 399) == 0);
      step();
      k++;
    end
    rst = 1'b0;
    chk("rand_drained", int'(q0.size() + q1.size()) + int'(pend0) + int'(pend1), 0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
